// File: rtl/bsg_vanilla_pkg.sv
// Shared types and RV32 encoding constants for the vanilla decode queue.
//   dq_mem_class_e : memory access class of a pre-decoded instruction
//   dq_dec_s       : pre-decode summary stored alongside each queued instruction
// Opcode/funct values are the RV32IMAF encodings.
package bsg_vanilla_pkg;

  // Major opcodes
  localparam logic [6:0] OpLui     = 7'b0110111;
  localparam logic [6:0] OpAuipc   = 7'b0010111;
  localparam logic [6:0] OpJal     = 7'b1101111;
  localparam logic [6:0] OpJalr    = 7'b1100111;
  localparam logic [6:0] OpBranch  = 7'b1100011;
  localparam logic [6:0] OpLoad    = 7'b0000011;
  localparam logic [6:0] OpStore   = 7'b0100011;
  localparam logic [6:0] OpImm     = 7'b0010011;
  localparam logic [6:0] OpOp      = 7'b0110011;
  localparam logic [6:0] OpMiscMem = 7'b0001111;
  localparam logic [6:0] OpSystem  = 7'b1110011;
  localparam logic [6:0] OpAmo     = 7'b0101111;
  localparam logic [6:0] OpLoadFp  = 7'b0000111;
  localparam logic [6:0] OpStoreFp = 7'b0100111;
  localparam logic [6:0] OpFp      = 7'b1010011;
  localparam logic [6:0] OpFmadd   = 7'b1000011;
  localparam logic [6:0] OpFmsub   = 7'b1000111;
  localparam logic [6:0] OpFnmsub  = 7'b1001011;
  localparam logic [6:0] OpFnmadd  = 7'b1001111;

  // funct7 for M extension on OP
  localparam logic [6:0] F7MulDiv  = 7'b0000001;

  // funct3 within M extension
  localparam logic [2:0] F3Mulh    = 3'b001;
  localparam logic [2:0] F3Mulhsu  = 3'b010;
  localparam logic [2:0] F3Mulhu   = 3'b011;

  // funct7 for OP_FP
  localparam logic [6:0] F7Fdiv    = 7'b0001100;
  localparam logic [6:0] F7Fsqrt   = 7'b0101100;
  localparam logic [6:0] F7Fcmp    = 7'b1010000;
  localparam logic [6:0] F7FclassMvXW = 7'b1110000;
  localparam logic [6:0] F7FcvtWS  = 7'b1100000;
  localparam logic [6:0] F7FcvtSW  = 7'b1101000;
  localparam logic [6:0] F7FmvWX   = 7'b1111000;

  // funct5 for AMO
  localparam logic [4:0] F5AmoAdd  = 5'b00000;
  localparam logic [4:0] F5AmoSwap = 5'b00001;
  localparam logic [4:0] F5Lr      = 5'b00010;
  localparam logic [4:0] F5AmoOr   = 5'b01000;

  typedef enum logic [2:0] {
    e_dq_none  = 3'd0,
    e_dq_load  = 3'd1,
    e_dq_store = 3'd2,
    e_dq_amo   = 3'd3,
    e_dq_lr    = 3'd4
  } dq_mem_class_e;

  typedef struct packed {
    logic          write_rd;
    logic          read_rs1;
    logic          read_rs2;
    dq_mem_class_e mem_class;
    logic          is_ctrl;
    logic          is_fp;
    logic          is_long;
    logic          is_fence;
    logic          is_csr;
    logic          unsupported;
  } dq_dec_s;

endpackage

// File: rtl/vanilla_predecode.sv
// Combinational pre-decoder: raw RV32 instruction word -> dq_dec_s summary.
// Ports:
//   instr_i : 32-bit instruction word
//   dec_o   : pre-decode summary (register usage, memory class, control flags)
module vanilla_predecode
  import bsg_vanilla_pkg::*;
(
  input  logic [31:0] instr_i,
  output dq_dec_s     dec_o
);

  logic [6:0] opcode;
  logic [4:0] rd;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] funct5;

  assign opcode = instr_i[6:0];
  assign rd     = instr_i[11:7];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];
  assign funct5 = instr_i[31:27];

  // Register specifier fields are not needed for the summary.
  logic unused_rs;
  assign unused_rs = ^instr_i[24:15];

  always_comb begin
    dec_o           = '0;
    dec_o.mem_class = e_dq_none;
    case (opcode)
      OpLui, OpAuipc: dec_o.write_rd = 1'b1;
      OpJal: begin
        dec_o.write_rd = 1'b1;
        dec_o.is_ctrl  = 1'b1;
      end
      OpJalr: begin
        dec_o.write_rd = 1'b1;
        dec_o.read_rs1 = 1'b1;
        dec_o.is_ctrl  = 1'b1;
      end
      OpBranch: begin
        dec_o.read_rs1 = 1'b1;
        dec_o.read_rs2 = 1'b1;
        dec_o.is_ctrl  = 1'b1;
      end
      OpLoad: begin
        dec_o.write_rd  = 1'b1;
        dec_o.read_rs1  = 1'b1;
        dec_o.mem_class = e_dq_load;
      end
      OpStore: begin
        dec_o.read_rs1  = 1'b1;
        dec_o.read_rs2  = 1'b1;
        dec_o.mem_class = e_dq_store;
      end
      OpLoadFp: begin
        dec_o.read_rs1  = 1'b1;
        dec_o.mem_class = e_dq_load;
      end
      OpStoreFp: begin
        // rs2 is an FP register here, so no integer rs2 read
        dec_o.read_rs1  = 1'b1;
        dec_o.mem_class = e_dq_store;
      end
      OpImm: begin
        dec_o.write_rd = 1'b1;
        dec_o.read_rs1 = 1'b1;
      end
      OpOp: begin
        dec_o.write_rd = 1'b1;
        dec_o.read_rs1 = 1'b1;
        dec_o.read_rs2 = 1'b1;
        if (funct7 == F7MulDiv) begin
          dec_o.is_long     = funct3[2];
          dec_o.unsupported = (funct3 == F3Mulh) || (funct3 == F3Mulhsu) ||
                              (funct3 == F3Mulhu);
        end
      end
      OpAmo: begin
        dec_o.write_rd  = 1'b1;
        dec_o.read_rs1  = 1'b1;
        dec_o.read_rs2  = (funct5 == F5AmoSwap) || (funct5 == F5AmoOr) ||
                          (funct5 == F5AmoAdd);
        dec_o.mem_class = (funct5 == F5Lr) ? e_dq_lr : e_dq_amo;
      end
      OpMiscMem: dec_o.is_fence = 1'b1;
      OpSystem: begin
        dec_o.write_rd = 1'b1;
        if (funct3 != 3'b000) begin
          dec_o.is_csr   = 1'b1;
          // funct3[2] selects the immediate (zimm) CSR forms
          dec_o.read_rs1 = !funct3[2];
        end
      end
      OpFp: begin
        dec_o.is_fp = 1'b1;
        case (funct7)
          F7Fcmp, F7FclassMvXW, F7FcvtWS: dec_o.write_rd = 1'b1;
          F7FcvtSW, F7FmvWX:              dec_o.read_rs1 = 1'b1;
          F7Fdiv, F7Fsqrt:                dec_o.is_long  = 1'b1;
          default: ;
        endcase
      end
      OpFmadd, OpFmsub, OpFnmsub, OpFnmadd: dec_o.is_fp = 1'b1;
      default: ;
    endcase
    if (rd == 5'd0) dec_o.write_rd = 1'b0;
  end

endmodule

// File: rtl/vanilla_decode_queue.sv
// Pre-decoding instruction queue between fetch and issue.
// Circular buffer of els_p entries; each entry holds instr, PC and its pre-decode.
// Optional same-cycle bypass on an empty queue: VANILLA_DECODE_QUEUE_BYPASS_EN.
// Ports:
//   clk_i, reset_n_i (synchronous, active-low)
//   flush_i                        : drop all entries, overrides enq/deq
//   enq_v_i/enq_ready_o            : enqueue handshake, enq_instr_i, enq_pc_i
//   deq_v_o/deq_yumi_i             : dequeue handshake, deq_instr_o, deq_pc_o, deq_dec_o
//   count_o                        : occupancy
//   unsup_cnt_o                    : saturating count of unsupported instructions enqueued
module vanilla_decode_queue
  import bsg_vanilla_pkg::*;
#(
  parameter int unsigned els_p       = 4,
  parameter int unsigned pc_width_p  = 22,
  parameter int unsigned cnt_width_p = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       flush_i,
  input  logic                       enq_v_i,
  output logic                       enq_ready_o,
  input  logic [31:0]                enq_instr_i,
  input  logic [pc_width_p-1:0]      enq_pc_i,
  output logic                       deq_v_o,
  input  logic                       deq_yumi_i,
  output logic [31:0]                deq_instr_o,
  output logic [pc_width_p-1:0]      deq_pc_o,
  output dq_dec_s                    deq_dec_o,
  output logic [$clog2(els_p+1)-1:0] count_o,
  output logic [cnt_width_p-1:0]     unsup_cnt_o
);

  localparam int unsigned PtrW = $clog2(els_p);
  localparam int unsigned CntW = $clog2(els_p + 1);
  localparam logic [CntW-1:0] CountFull = CntW'(els_p);

  logic [31:0]           instr_mem [els_p];
  logic [pc_width_p-1:0] pc_mem    [els_p];
  dq_dec_s               dec_mem   [els_p];

  logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]        count_q, count_d;
  logic [cnt_width_p-1:0] unsup_q, unsup_d;

  dq_dec_s enq_dec;
  logic    empty, full, enq_fire, deq_fire, wr_en, rd_adv, bypass;

  vanilla_predecode u_predecode (
    .instr_i (enq_instr_i),
    .dec_o   (enq_dec)
  );

  assign empty       = (count_q == '0);
  assign full        = (count_q == CountFull);
  assign enq_ready_o = !full && !flush_i;
  assign enq_fire    = enq_v_i && enq_ready_o;

`ifdef VANILLA_DECODE_QUEUE_BYPASS_EN
  assign bypass      = empty && enq_v_i && !flush_i;
  assign deq_v_o     = !empty || bypass;
  assign deq_instr_o = bypass ? enq_instr_i : instr_mem[rd_ptr_q];
  assign deq_pc_o    = bypass ? enq_pc_i    : pc_mem[rd_ptr_q];
  assign deq_dec_o   = bypass ? enq_dec     : dec_mem[rd_ptr_q];
`else
  assign bypass      = 1'b0;
  assign deq_v_o     = !empty;
  assign deq_instr_o = instr_mem[rd_ptr_q];
  assign deq_pc_o    = pc_mem[rd_ptr_q];
  assign deq_dec_o   = dec_mem[rd_ptr_q];
`endif

  assign deq_fire = deq_yumi_i && deq_v_o && !flush_i;
  // A bypassed instruction taken in the same cycle never occupies storage.
  assign wr_en    = enq_fire && !(bypass && deq_fire);
  assign rd_adv   = deq_fire && !bypass;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en)  wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (rd_adv) rd_ptr_d = rd_ptr_q + PtrW'(1);
      case ({wr_en, rd_adv})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    unsup_d = unsup_q;
    if (enq_fire && enq_dec.unsupported && (unsup_q != '1)) begin
      unsup_d = unsup_q + cnt_width_p'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      unsup_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      unsup_q  <= unsup_d;
    end
  end

  // Entry storage is intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (reset_n_i && wr_en) begin
      instr_mem[wr_ptr_q] <= enq_instr_i;
      pc_mem[wr_ptr_q]    <= enq_pc_i;
      dec_mem[wr_ptr_q]   <= enq_dec;
    end
  end

  assign count_o     = count_q;
  assign unsup_cnt_o = unsup_q;

  a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    deq_yumi_i |-> deq_v_o);

  a_no_enq_when_not_ready: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(enq_v_i && !enq_ready_o && wr_en));

endmodule

// File: tb/tb_vanilla_decode_queue.sv
module tb_vanilla_decode_queue;
  import bsg_vanilla_pkg::*;

  localparam int unsigned PcW = 22;

  localparam logic [31:0] IAddi = 32'h00500093;
  localparam logic [31:0] ILw   = 32'h0000A103;
  localparam logic [31:0] IBeq  = 32'h00000063;
  localparam logic [31:0] IMulh = 32'h022091B3;

  logic           clk = 1'b0;
  logic           reset_n, flush, enq_v, yumi;
  logic [31:0]    enq_instr;
  logic [PcW-1:0] enq_pc;

  logic           enq_ready, deq_v;
  logic [31:0]    deq_instr;
  logic [PcW-1:0] deq_pc;
  dq_dec_s        deq_dec;
  logic [2:0]     count;
  logic [15:0]    unsup;

  logic           s_enq_ready, s_deq_v;
  logic [31:0]    s_deq_instr;
  logic [PcW-1:0] s_deq_pc;
  dq_dec_s        s_deq_dec;
  logic [2:0]     s_count;
  logic [1:0]     s_unsup;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vanilla_decode_queue #(.els_p(4), .pc_width_p(PcW), .cnt_width_p(16)) u_dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .flush_i     (flush),
    .enq_v_i     (enq_v),
    .enq_ready_o (enq_ready),
    .enq_instr_i (enq_instr),
    .enq_pc_i    (enq_pc),
    .deq_v_o     (deq_v),
    .deq_yumi_i  (yumi),
    .deq_instr_o (deq_instr),
    .deq_pc_o    (deq_pc),
    .deq_dec_o   (deq_dec),
    .count_o     (count),
    .unsup_cnt_o (unsup)
  );

  // Narrow counter instance for saturation, driven by the same stimulus.
  vanilla_decode_queue #(.els_p(4), .pc_width_p(PcW), .cnt_width_p(2)) u_sat (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .flush_i     (flush),
    .enq_v_i     (enq_v),
    .enq_ready_o (s_enq_ready),
    .enq_instr_i (enq_instr),
    .enq_pc_i    (enq_pc),
    .deq_v_o     (s_deq_v),
    .deq_yumi_i  (yumi),
    .deq_instr_o (s_deq_instr),
    .deq_pc_o    (s_deq_pc),
    .deq_dec_o   (s_deq_dec),
    .count_o     (s_count),
    .unsup_cnt_o (s_unsup)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; enq_v = 1'b0; yumi = 1'b0;
    enq_instr = '0; enq_pc = '0;
    cyc(); cyc();
    reset_n = 1'b1;
    #1;
    chk("rst_count", count, 3'd0);
    chk("rst_deq_v", deq_v, 1'b0);
    chk("rst_enq_ready", enq_ready, 1'b1);
    chk("rst_unsup", unsup, 16'd0);

    // addi x1,x0,5
    enq_v = 1'b1; enq_instr = IAddi; enq_pc = 22'h100;
    cyc();
    enq_v = 1'b0;
    #1;
    chk("addi_deq_v", deq_v, 1'b1);
    chk("addi_instr", deq_instr, IAddi);
    chk("addi_pc", deq_pc, 22'h100);
    chk("addi_write_rd", deq_dec.write_rd, 1'b1);
    chk("addi_rs1", deq_dec.read_rs1, 1'b1);
    chk("addi_rs2", deq_dec.read_rs2, 1'b0);
    chk("addi_mem", deq_dec.mem_class, e_dq_none);
    chk("addi_count", count, 3'd1);
    yumi = 1'b1;
    cyc();
    yumi = 1'b0;
    #1;
    chk("addi_drained_count", count, 3'd0);
    chk("addi_drained_v", deq_v, 1'b0);

    // lw then beq back to back
    enq_v = 1'b1; enq_instr = ILw; enq_pc = 22'h104;
    cyc();
    enq_instr = IBeq; enq_pc = 22'h108;
    cyc();
    enq_v = 1'b0;
    #1;
    chk("lwbeq_count", count, 3'd2);
    chk("lw_instr", deq_instr, ILw);
    chk("lw_mem", deq_dec.mem_class, e_dq_load);
    chk("lw_write_rd", deq_dec.write_rd, 1'b1);
    yumi = 1'b1;
    cyc();
    chk("beq_instr", deq_instr, IBeq);
    chk("beq_pc", deq_pc, 22'h108);
    chk("beq_ctrl", deq_dec.is_ctrl, 1'b1);
    chk("beq_rs2", deq_dec.read_rs2, 1'b1);
    chk("beq_write_rd", deq_dec.write_rd, 1'b0);
    chk("beq_mem", deq_dec.mem_class, e_dq_none);
    chk("beq_count", count, 3'd1);
    cyc();
    yumi = 1'b0;
    #1;
    chk("lwbeq_drained", count, 3'd0);

    // Fill to capacity (pointers start mid-buffer, so this wraps)
    enq_instr = IAddi;
    for (int i = 0; i < 4; i++) begin
      enq_v = 1'b1; enq_pc = PcW'(32'h10 + 4 * i);
      cyc();
    end
    enq_v = 1'b0;
    #1;
    chk("full_ready", enq_ready, 1'b0);
    chk("full_count", count, 3'd4);
    chk("full_head_pc", deq_pc, 22'h10);
    yumi = 1'b1;
    cyc();
    yumi = 1'b0;
    #1;
    chk("drain1_count", count, 3'd3);
    chk("drain1_ready", enq_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      enq_v = 1'b1; yumi = 1'b1; enq_pc = PcW'(32'h20 + 4 * i);
      #1;
      chk("encdeq_head_pc", deq_pc, PcW'(32'h14 + 4 * i));
      cyc();
      chk("encdeq_count", count, 3'd3);
    end
    enq_v = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("wrap_pc", deq_pc, PcW'(32'h24 + 4 * i));
      cyc();
    end
    yumi = 1'b0;
    #1;
    chk("wrap_drained", count, 3'd0);

    // mulh x3 times, then flush with a concurrent enqueue
    enq_instr = IMulh;
    for (int i = 0; i < 3; i++) begin
      enq_v = 1'b1; enq_pc = PcW'(32'h200 + 4 * i);
      cyc();
    end
    enq_v = 1'b0;
    #1;
    chk("mulh_unsup", unsup, 16'd3);
    chk("mulh_unsup_sat", s_unsup, 2'd3);
    chk("mulh_dec_unsup", deq_dec.unsupported, 1'b1);
    chk("mulh_count", count, 3'd3);
    flush = 1'b1; enq_v = 1'b1; enq_instr = IAddi; enq_pc = 22'h300;
    #1;
    chk("flush_ready", enq_ready, 1'b0);
    cyc();
    flush = 1'b0; enq_v = 1'b0;
    #1;
    chk("flush_count", count, 3'd0);
    chk("flush_deq_v", deq_v, 1'b0);
    chk("flush_unsup", unsup, 16'd3);
    enq_v = 1'b1; enq_instr = IBeq; enq_pc = 22'h400;
    cyc();
    enq_v = 1'b0;
    #1;
    chk("postflush_count", count, 3'd1);
    chk("postflush_pc", deq_pc, 22'h400);
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    #1;
    chk("rst2_unsup", unsup, 16'd0);
    chk("rst2_unsup_sat", s_unsup, 2'd0);
    chk("rst2_count", count, 3'd0);

    // Five mulh: first alone, then four with concurrent yumi
    enq_v = 1'b1; enq_instr = IMulh; enq_pc = 22'h500;
    cyc();
    yumi = 1'b1;
    for (int i = 1; i < 5; i++) begin
      enq_pc = PcW'(32'h500 + 4 * i);
      cyc();
    end
    enq_v = 1'b0;
    #1;
    chk("mulh5_unsup", unsup, 16'd5);
    chk("mulh5_unsup_sat", s_unsup, 2'd3);
    chk("mulh5_count", count, 3'd1);
    cyc();
    yumi = 1'b0;
    #1;
    chk("mulh5_drained", count, 3'd0);

    // Same-cycle behaviour on an empty queue
    enq_v = 1'b1; enq_instr = ILw; enq_pc = 22'h600;
`ifdef VANILLA_DECODE_QUEUE_BYPASS_EN
    yumi = 1'b1;
    #1;
    chk("byp_deq_v", deq_v, 1'b1);
    chk("byp_instr", deq_instr, ILw);
    chk("byp_pc", deq_pc, 22'h600);
    chk("byp_mem", deq_dec.mem_class, e_dq_load);
    cyc();
    enq_v = 1'b0; yumi = 1'b0;
    #1;
    chk("byp_count", count, 3'd0);
    chk("byp_after_v", deq_v, 1'b0);
`else
    #1;
    chk("nobyp_deq_v", deq_v, 1'b0);
    cyc();
    enq_v = 1'b0;
    #1;
    chk("nobyp_count", count, 3'd1);
    chk("nobyp_after_v", deq_v, 1'b1);
    chk("nobyp_instr", deq_instr, ILw);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
